// File: rtl/ifetch_pkg.sv
// Shared definitions for the CPU54 instruction fetch front end.
// Holds FSM state encodings, the empty-head NOP value and the reset fetch address.
// Also defines the FIFO entry layout {pc, word} and a PC alignment helper.
package ifetch_pkg;

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_WAIT = 2'd1;
    localparam logic [1:0] ST_DROP = 2'd2;

    localparam logic [31:0] NOP_INSTR        = 32'h0000_0000;
    localparam logic [31:0] DEFAULT_RESET_PC = 32'h0040_0000;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] word;
    } fetch_entry_t;

    // Instruction addresses are word aligned; the low two bits are dropped.
    function automatic logic [31:0] align_pc(input logic [31:0] addr);
        return {addr[31:2], 2'b00};
    endfunction

endpackage

// File: rtl/ifetch_fifo.sv
// Prefetch FIFO holding {pc, word} entries between instruction memory and decoder.
// Latency: a push is visible at the head the cycle after; push and pop may coincide.
// Backpressure: the caller never pushes when full; flush empties it on the same edge.
module ifetch_fifo
    import ifetch_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     flush,
    input  logic                     push,
    input  fetch_entry_t             push_data,
    input  logic                     pop,
    output logic [$clog2(DEPTH):0]   count,
    output logic                     head_valid,
    output fetch_entry_t             head_data
);

    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] FULL_CNT = (AW + 1)'(DEPTH);

    fetch_entry_t mem [DEPTH];
    logic [AW-1:0] rd_ptr;
    logic [AW-1:0] wr_ptr;
    logic          do_push;
    logic          do_pop;

    assign do_push    = push && (count != FULL_CNT);
    assign do_pop     = pop && (count != '0);
    assign head_valid = (count != '0);
    // Head is zeroed when empty so the decoder sees a NOP at PC 0.
    assign head_data  = head_valid ? mem[rd_ptr] : '0;

    // Pointer and occupancy tracking; flush wins over push/pop.
    always_ff @(posedge clk) begin
        if (rst || flush) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + 1'b1;
            if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
            if (do_push && !do_pop)
                count <= count + 1'b1;
            else if (!do_push && do_pop)
                count <= count - 1'b1;
        end
    end

    // Entry storage; contents are don't-care until written.
    always_ff @(posedge clk) begin
        if (do_push && !flush && !rst)
            mem[wr_ptr] <= push_data;
    end

endmodule

// File: rtl/ifetch_unit.sv
// Instruction fetch: owns fetch PC, issues one outstanding imem read, buffers words.
// Latency: ack at edge N gives instr_valid in cycle N+1; one word per cycle sustained.
// Backpressure: fetch stops issuing while the prefetch FIFO is full; redirect flushes.
module ifetch_unit
    import ifetch_pkg::*;
#(
    parameter logic [31:0] RESET_PC   = DEFAULT_RESET_PC,
    parameter int          FIFO_DEPTH = 4
) (
    input  logic        clk,
    input  logic        rst,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_ack,
    input  logic [31:0] imem_rdata,
    input  logic        redirect,
    input  logic [31:0] redirect_pc,
    output logic        instr_valid,
    input  logic        instr_ready,
    output logic [31:0] instruction,
    output logic [31:0] instr_pc
);

    localparam int CW = $clog2(FIFO_DEPTH) + 1;
    localparam logic [CW-1:0] FULL_CNT = CW'(FIFO_DEPTH);

    logic [1:0]    state;
    logic [31:0]   fetch_pc;
    logic [31:0]   fetch_pc_inc;
    logic [CW-1:0] count;
    logic [CW-1:0] count_after;
    logic          ack_ok;
    logic          push;
    logic          pop;
    logic          head_valid;
    fetch_entry_t  head_data;
    fetch_entry_t  push_data;

    // Acks only count while a request is actually on the bus.
    assign ack_ok       = imem_req && imem_ack;
    assign pop          = instr_valid && instr_ready;
    assign push         = (state == ST_WAIT) && ack_ok && !redirect;
    assign fetch_pc_inc = fetch_pc + 32'd4;
    assign push_data    = '{pc: fetch_pc, word: imem_rdata};

    // Occupancy after this cycle's push/pop decides whether to keep streaming.
    always_comb begin
        count_after = count;
        if (push && !pop)
            count_after = count + 1'b1;
        else if (!push && pop)
            count_after = count - 1'b1;
    end

    // Fetch FSM: redirect first, then ack handling, then new issue.
    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= ST_IDLE;
            fetch_pc  <= RESET_PC;
            imem_req  <= 1'b0;
            imem_addr <= RESET_PC;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (redirect) begin
                        fetch_pc <= align_pc(redirect_pc);
                    end else if (count < FULL_CNT) begin
                        imem_req  <= 1'b1;
                        imem_addr <= fetch_pc;
                        state     <= ST_WAIT;
                    end
                end
                ST_WAIT: begin
                    if (redirect) begin
                        fetch_pc <= align_pc(redirect_pc);
                        if (ack_ok) begin
                            // Returned word belongs to the old stream: drop it.
                            imem_req <= 1'b0;
                            state    <= ST_IDLE;
                        end else begin
                            // Memory cannot be aborted; let the stale read finish.
                            state <= ST_DROP;
                        end
                    end else if (ack_ok) begin
                        fetch_pc <= fetch_pc_inc;
                        if (count_after < FULL_CNT) begin
                            imem_addr <= fetch_pc_inc;
                        end else begin
                            imem_req <= 1'b0;
                            state    <= ST_IDLE;
                        end
                    end
                end
                ST_DROP: begin
                    if (redirect)
                        fetch_pc <= align_pc(redirect_pc);
                    if (ack_ok) begin
                        imem_req <= 1'b0;
                        state    <= ST_IDLE;
                    end
                end
                default: begin
                    imem_req <= 1'b0;
                    state    <= ST_IDLE;
                end
            endcase
        end
    end

    ifetch_fifo #(
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk        (clk),
        .rst        (rst),
        .flush      (redirect),
        .push       (push),
        .push_data  (push_data),
        .pop        (pop),
        .count      (count),
        .head_valid (head_valid),
        .head_data  (head_data)
    );

    assign instr_valid = head_valid;
    assign instruction = head_data.word;
    assign instr_pc    = head_data.pc;

endmodule
